// File: rtl/reg_scoreboard.sv
// Register scoreboard and issue scheduler: per-register pending-write counters,
// source/WAW stall generation and a RUN/DRAIN/DONE drain sequencer.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_wen,
  input  logic [AW-1:0]   issue_rd,
  input  logic            read1_flag,
  input  logic [AW-1:0]   read1_address,
  input  logic            read2_flag,
  input  logic [AW-1:0]   read2_address,
  input  logic            wb_flag,
  input  logic [AW-1:0]   wb_address,
  input  logic            flush,
  input  logic            drain_req,
  output logic            stall,
  output logic            issue_fire,
  output logic            drain_done,
  output logic [AW+CW-1:0] inflight
);

  localparam int IW = AW + CW;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [IW-1:0]   inflight_q, inflight_d;

  logic hit1, hit2, hit_rd;
  logic pend1, pend2, src_stall, waw_full;
  logic inc_any, dec_any, inc, dec;

  always_comb begin
    hit1   = wb_flag && (wb_address == read1_address) && (read1_address != '0);
    hit2   = wb_flag && (wb_address == read2_address) && (read2_address != '0);
    hit_rd = wb_flag && (wb_address == issue_rd) && (issue_rd != '0);

    // A source is still busy unless its only pending write retires this cycle
    pend1 = (cnt_q[read1_address] != '0) && !(hit1 && cnt_q[read1_address] == CW'(1));
    pend2 = (cnt_q[read2_address] != '0) && !(hit2 && cnt_q[read2_address] == CW'(1));
    src_stall = (read1_flag && pend1) || (read2_flag && pend2);
    waw_full  = issue_wen && (issue_rd != '0) && (cnt_q[issue_rd] == CNT_MAX) && !hit_rd;

    stall      = !rst && issue_valid && (src_stall || waw_full || state_q != RUN);
    issue_fire = !rst && issue_valid && !stall;
    drain_done = (state_q == DONE);

    inc_any = issue_fire && issue_wen && (issue_rd != '0);
    dec_any = wb_flag && (wb_address != '0) && (cnt_q[wb_address] != '0);

    inc = 1'b0;
    dec = 1'b0;
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc = inc_any && (issue_rd == AW'(r));
      dec = dec_any && (wb_address == AW'(r));
      cnt_d[r] = cnt_q[r];
      if (flush)            cnt_d[r] = '0;
      else if (inc && !dec) cnt_d[r] = cnt_q[r] + CW'(1);
      else if (dec && !inc) cnt_d[r] = cnt_q[r] - CW'(1);
    end

    inflight_d = inflight_q;
    if (flush)                    inflight_d = '0;
    else if (inc_any && !dec_any) inflight_d = inflight_q + IW'(1);
    else if (dec_any && !inc_any) inflight_d = inflight_q - IW'(1);

    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (inflight_d == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      inflight_q <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign inflight = inflight_q;

endmodule
